sample_pipe_out_streamer: RTL and testbench

Captures one 32-bit simulation value (spike count, force, Ia rate, …) on every rising edge of the simulation clock and streams it to the host as 16-bit words over the Opal Kelly block-throttled pipe-out endpoint. It is the device-to-host counterpart of the pipe-in waveform loader, sitting between the `sim_clk` datapath and an `okBTPipeOut` on the host-interface clock. It exists to replace polled `okWireOut` pairs with a gap-free recording.

---
 rtl/sample_pipe_out_streamer_if.sv | 24 ++
 rtl/sample_pipe_out_streamer.sv | 200 ++++++++++++++++++++
 tb/tb_sample_pipe_out_streamer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_pipe_out_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_pipe_out_streamer_if
// Brief    : Block-throttled pipe-out handshake between streamer and endpoint.
// Revision : 1.0
// ============================================================================
interface sample_pipe_out_streamer_if;
    logic        ep_read;
    logic [15:0] ep_datain;
    logic        ep_ready;

    modport master (
        input  ep_read,
        output ep_datain,
        output ep_ready
    );

    modport slave (
        output ep_read,
        input  ep_datain,
        input  ep_ready
    );
endinterface
`default_nettype wire

// File: rtl/sample_pipe_out_streamer.sv
`default_nettype none
// ============================================================================
// Module   : sample_pipe_out_streamer
// Brief    : Records one 32-bit value per sample_clk rise into a FWFT FIFO
//            read out as 16-bit words; SAMPLE_TAG_EN adds a sequence tag word.
// Revision : 1.0
// ============================================================================
module sample_pipe_out_streamer #(
    parameter int AW          = 11,
    parameter int BLOCK_WORDS = 256
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  sample_clk,
    input  wire logic                  enable,
    input  wire logic [31:0]           sample_data,
    sample_pipe_out_streamer_if.master pipe,
    output logic [AW:0]                fill_count,
    output logic [15:0]                overflow_cnt,
    output logic                       underflow
);

    localparam logic [AW:0]   c_depth   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   c_cnt_one = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_ptr_one = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_block   = (AW+1)'(BLOCK_WORDS);
`ifdef SAMPLE_TAG_EN
    localparam logic [AW:0]   c_wps     = (AW+1)'(3);
`else
    localparam logic [AW:0]   c_wps     = (AW+1)'(2);
`endif

`ifdef SAMPLE_TAG_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_LO  = 2'd1,
        WR_HI  = 2'd2,
        WR_TAG = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_LO  = 2'd1,
        WR_HI  = 2'd2
    } state_t;
`endif

    state_t         r_state;
    state_t         w_next;

    logic           r_sync1;
    logic           r_sync2;
    logic           r_sync3;
    logic           w_stb;
    logic           w_qual;

    logic [31:0]    r_sample;
    logic [15:0]    r_mem [0:(1<<AW)-1];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_fill;
    logic [AW:0]    w_free;
    logic [15:0]    r_ovf;
    logic           r_underflow;
    logic           r_ready;

    logic           w_wr;
    logic [15:0]    w_wdata;
    logic           w_start;
    logic           w_drop;
    logic           w_pop;

`ifdef SAMPLE_TAG_EN
    logic [15:0]    r_tag;
`endif

    assign w_stb  = r_sync2 & ~r_sync3;
    assign w_qual = w_stb & enable;
    // Free space deliberately ignores a pop in the same cycle.
    assign w_free = c_depth - r_fill;
    assign w_pop  = pipe.ep_read & (r_fill != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_wdata = 16'h0000;
        w_start = 1'b0;
        w_drop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_qual) begin
                    if (w_free >= c_wps) begin
                        w_start = 1'b1;
`ifdef SAMPLE_TAG_EN
                        w_next  = WR_TAG;
`else
                        w_next  = WR_LO;
`endif
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
`ifdef SAMPLE_TAG_EN
            WR_TAG: begin
                w_wr    = 1'b1;
                w_wdata = r_tag;
                w_next  = WR_LO;
            end
`endif
            WR_LO: begin
                w_wr    = 1'b1;
                w_wdata = r_sample[15:0];
                w_next  = WR_HI;
            end
            WR_HI: begin
                w_wr    = 1'b1;
                w_wdata = r_sample[31:16];
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // A strobe while a sample is still being written cannot be stored.
        if (w_qual && (r_state != IDLE)) begin
            w_drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_sample    <= 32'h0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fill      <= '0;
            r_ovf       <= 16'h0000;
            r_underflow <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_sync1 <= sample_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_start) begin
                r_sample <= sample_data;
            end
            if (w_wr) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_wr, w_pop})
                2'b10:   r_fill <= r_fill + c_cnt_one;
                2'b01:   r_fill <= r_fill - c_cnt_one;
                default: r_fill <= r_fill;
            endcase
            if (w_drop && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
            if (pipe.ep_read && (r_fill == '0)) begin
                r_underflow <= 1'b1;
            end
            r_ready <= (r_fill >= c_block);
        end
    end

`ifdef SAMPLE_TAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag <= 16'h0000;
        end else if (r_state == WR_TAG) begin
            r_tag <= r_tag + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    assign pipe.ep_datain = (r_fill != '0) ? r_mem[r_rptr] : 16'h0000;
    assign pipe.ep_ready  = r_ready;
    assign fill_count     = r_fill;
    assign overflow_cnt   = r_ovf;
    assign underflow      = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sample_pipe_out_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_pipe_out_streamer
// Brief    : Randomized scoreboard bench for sample_pipe_out_streamer.
// Revision : 1.0
// ============================================================================
module tb_sample_pipe_out_streamer;

    localparam int AW          = 11;
    localparam int BLOCK_WORDS = 256;
    localparam int DEPTH       = 1 << AW;
`ifdef SAMPLE_TAG_EN
    localparam int WPS = 3;
`else
    localparam int WPS = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_clk;
    logic        enable;
    logic [31:0] sample_data;
    wire  [AW:0] fill_count;
    wire  [15:0] overflow_cnt;
    wire         underflow;

    sample_pipe_out_streamer_if pipe_if ();

    sample_pipe_out_streamer #(
        .AW          (AW),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_clk   (sample_clk),
        .enable       (enable),
        .sample_data  (sample_data),
        .pipe         (pipe_if),
        .fill_count   (fill_count),
        .overflow_cnt (overflow_cnt),
        .underflow    (underflow)
    );

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          exp_ovf = 0;
    logic [15:0] exp_tag = 16'h0000;
    logic        rd_en = 1'b0;
    logic        rd_force = 1'b0;
    int          rd_pct = 100;
    logic        watch_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a stored sample is its (tag,) low and high half-words.
    task automatic model_sample(input logic [31:0] data, input logic en);
        if (en) begin
            if (DEPTH - exp_q.size() >= WPS) begin
`ifdef SAMPLE_TAG_EN
                exp_q.push_back(exp_tag);
                exp_tag = exp_tag + 16'd1;
`endif
                exp_q.push_back(data[15:0]);
                exp_q.push_back(data[31:16]);
            end else if (exp_ovf != 16'hFFFF) begin
                exp_ovf++;
            end
        end
    endtask

    // Host reader
    initial begin
        pipe_if.ep_read = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pipe_if.ep_read = rd_force ||
                (rd_en && (fill_count != 0) && ($urandom_range(99) < rd_pct));
        end
    end

    // Scoreboard monitor: every consumed word is compared in order.
    initial forever begin
        @(negedge clk);
        if (!reset && pipe_if.ep_read && (fill_count != 0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_extra actual=%0h required=none at %0t", pipe_if.ep_datain, $time);
            end else begin
                check("ep_datain", {16'h0, pipe_if.ep_datain}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // ep_ready must trail the cycle in which fill_count first reaches a block.
    initial forever begin
        @(negedge clk);
        if (watch_ready && (fill_count >= BLOCK_WORDS)) begin
            check("ready_lag", {31'h0, pipe_if.ep_ready}, 32'd0);
            @(negedge clk);
            check("ready_rise", {31'h0, pipe_if.ep_ready}, 32'd1);
            watch_ready = 1'b0;
        end
    end

    task automatic do_sample(input logic [31:0] data, input logic en);
        @(posedge clk);
        #1;
        sample_data = data;
        enable      = en;
        model_sample(data, en);
        @(posedge clk);
        #1;
        sample_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sample_clk = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic drain();
        rd_pct = 100;
        rd_en  = 1'b1;
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_remaining", exp_q.size(), 32'd0);
        rd_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain_fill", {20'h0, fill_count}, 32'd0);
        check("drain_datain", {16'h0, pipe_if.ep_datain}, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_fill"},     {20'h0, fill_count},          32'd0);
        check({tag, "_ready"},    {31'h0, pipe_if.ep_ready},    32'd0);
        check({tag, "_datain"},   {16'h0, pipe_if.ep_datain},   32'd0);
        check({tag, "_overflow"}, {16'h0, overflow_cnt},        32'd0);
        check({tag, "_underflow"},{31'h0, underflow},           32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        sample_clk  = 1'b0;
        enable      = 1'b0;
        sample_data = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        // Single sample
        do_sample(32'h3F80_0000, 1'b1);
        @(negedge clk);
        check("single_fill", {20'h0, fill_count}, WPS);
        check("single_ready", {31'h0, pipe_if.ep_ready}, 32'd0);
        drain();
        check("single_underflow", {31'h0, underflow}, 32'd0);

        // One block's worth of ascending samples, no reads
        watch_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            do_sample(i, 1'b1);
            @(negedge clk);
            check("blk_fill", {20'h0, fill_count}, exp_q.size());
            check("blk_ready", {31'h0, pipe_if.ep_ready}, (exp_q.size() >= BLOCK_WORDS) ? 32'd1 : 32'd0);
        end
        check("ready_seen", {31'h0, watch_ready}, 32'd0);
        watch_ready = 1'b0;
        drain();

        // Overfill
        for (int i = 0; i < 1025; i++) do_sample(i, 1'b1);
        @(negedge clk);
        check("full_fill", {20'h0, fill_count}, exp_q.size());
        check("full_overflow", {16'h0, overflow_cnt}, exp_ovf);
        check("full_ready", {31'h0, pipe_if.ep_ready}, 32'd1);
        drain();

        // Random data and enable with concurrent host reads, across many wraps
        rd_pct = 60;
        rd_en  = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            do_sample($urandom, ($urandom_range(9) != 0));
        end
        drain();
        check("rand_overflow", {16'h0, overflow_cnt}, exp_ovf);
        check("rand_underflow", {31'h0, underflow}, 32'd0);

        // Reset in the middle of a sample
        @(posedge clk);
        #1;
        sample_data = 32'hA5A5_5A5A;
        enable      = 1'b1;
        @(posedge clk);
        #1;
        sample_clk = 1'b1;
        for (int n = 0; n < 20 && fill_count == 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("midsample_started", {31'h0, (fill_count != 0)}, 32'd1);
        reset      = 1'b1;
        sample_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 0;
        exp_tag = 16'h0000;
        @(negedge clk);
        check_zero_outputs("midreset");
        repeat (6) @(negedge clk);
        check("partial_discarded", {20'h0, fill_count}, 32'd0);

        // Read while empty
        @(posedge clk);
        rd_force = 1'b1;
        @(negedge clk);
        check("empty_datain", {16'h0, pipe_if.ep_datain}, 32'd0);
        @(posedge clk);
        rd_force = 1'b0;
        @(negedge clk);
        check("empty_underflow", {31'h0, underflow}, 32'd1);
        check("empty_fill", {20'h0, fill_count}, 32'd0);
        check("empty_datain_after", {16'h0, pipe_if.ep_datain}, 32'd0);

        // Storage restarts cleanly after reset
        do_sample(32'h1234_5678, 1'b1);
        do_sample(32'h9ABC_DEF0, 1'b1);
        do_sample(32'h0F0F_F0F0, 1'b1);
        @(negedge clk);
        check("post_fill", {20'h0, fill_count}, 3 * WPS);
        drain();
        check("underflow_sticky", {31'h0, underflow}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
